mem_arbiter: RTL and testbench

- Shares the single-port program/data memory between the CPU sequencer (mem_rd/mem_wr strobes from the control FSM) and an external loader/debug port.
- Loader port uses a req/gnt handshake.
- The CPU has default priority.
- A starvation counter forces loader grants, and a lock input allows bounded loader bursts.
- Sits between the CPU and the memory model in the top level; the CPU holds its state while cpu_stall is high.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 65 ++++++
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM states, read-return owner tags,
// and the small counter type used by the starvation and burst counters.
package mem_arbiter_pkg;

  // Arbiter FSM: default CPU priority, or an ongoing locked loader burst.
  typedef enum logic [0:0] {
    ARB_CPU = 1'b0,
    ARB_LDR = 1'b1
  } arb_state_t;

  // Who owns the memory in a given cycle; also tags in-flight reads.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_LDR  = 2'd2
  } rd_owner_t;

  // MAX_WAIT and BURST_MAX are both limited to 1..15, so 4 bits suffice.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

  // Increment that sticks at the limit instead of wrapping.
  function automatic cnt_t cnt_inc_sat(input cnt_t cnt, input cnt_t lim);
    return (cnt >= lim) ? cnt : cnt + cnt_t'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU sequencer, the loader/debug port, the arbiter
// and the single-port memory.
//
// Handshakes:
//   Loader: ldr_req is the loader's valid, ldr_gnt is the arbiter's ready.
//   A beat (read or write) transfers in exactly the cycles where ldr_req and
//   ldr_gnt are both high; ldr_gnt is combinational, so the access happens in
//   the grant cycle. The loader keeps ldr_we/ldr_addr/ldr_wdata stable while
//   ldr_req is high and ldr_gnt is low. Read data returns one cycle after the
//   granted read beat, qualified by ldr_rvalid (no backpressure on returns).
//   CPU: cpu_rd|cpu_wr is the CPU's valid and !cpu_stall is the ready; the
//   CPU holds its strobes, address and data while cpu_stall is high.
//   cpu_rdata follows mem_rdata unconditionally.
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  // CPU side
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  // Loader side
  logic              ldr_req;
  logic              ldr_we;
  logic              ldr_lock;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;
  // Memory side
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic              err;

  // Arbiter view.
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata,
    output err
  );

  // Requester/memory view (CPU, loader and memory model together).
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata,
    input  err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port program/data memory between the CPU
// sequencer and the external loader. CPU has priority; a starvation counter
// forces a loader grant after MAX_WAIT contended cycles, and ldr_lock keeps
// the loader on the memory for up to BURST_MAX beats while the CPU waits.
// Grants are combinational: the access happens in the grant cycle.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output arb_state_t    dbg_state
);

  localparam cnt_t MAX_WAIT_C  = cnt_t'(MAX_WAIT);
  localparam cnt_t BURST_MAX_C = cnt_t'(BURST_MAX);

  arb_state_t state, state_nxt;
  cnt_t       wait_cnt, wait_nxt;
  cnt_t       beat_cnt, beat_nxt;
  rd_owner_t  rd_owner, rd_owner_nxt;
  rd_owner_t  owner;
  rd_owner_t  cpu_rule_owner;
  cnt_t       cpu_rule_wait;
  logic       cpu_req;
  logic       cpu_is_rd;
  logic       cpu_is_wr;
  logic       mem_rd_c;
  logic       mem_wr_c;
  logic       err_q;
  logic [ADDR_W-1:0] mux_addr;
  logic [DATA_W-1:0] mux_wdata;

  // Decode CPU strobes; a simultaneous read+write is treated as a write.
  always_comb begin
    cpu_req   = bus.cpu_rd | bus.cpu_wr;
    cpu_is_wr = bus.cpu_wr;
    cpu_is_rd = bus.cpu_rd & ~bus.cpu_wr;
  end

  // Default-priority decision: CPU wins unless the loader has waited long enough.
  always_comb begin
    cpu_rule_owner = RD_NONE;
    cpu_rule_wait  = '0;
    if (bus.ldr_req && (!cpu_req || wait_cnt >= MAX_WAIT_C)) begin
      cpu_rule_owner = RD_LDR;
    end else if (cpu_req) begin
      cpu_rule_owner = RD_CPU;
      // Only a contended cycle lost by the loader counts towards starvation.
      if (bus.ldr_req) begin
        cpu_rule_wait = wait_cnt + cnt_t'(1);
      end
    end
  end

  // FSM next state, memory owner and counter updates.
  always_comb begin
    state_nxt = state;
    owner     = RD_NONE;
    wait_nxt  = '0;
    beat_nxt  = '0;
    case (state)
      ARB_CPU: begin
        owner    = cpu_rule_owner;
        wait_nxt = cpu_rule_wait;
        if (cpu_rule_owner == RD_LDR && bus.ldr_lock) begin
          state_nxt = ARB_LDR;
          beat_nxt  = cnt_t'(1);
        end
      end
      ARB_LDR: begin
        if (bus.ldr_req && bus.ldr_lock) begin
          if (beat_cnt >= BURST_MAX_C && cpu_req) begin
            // Burst limit reached with the CPU waiting: hand memory back now.
            owner     = RD_CPU;
            state_nxt = ARB_CPU;
          end else begin
            // Without a waiting CPU the burst may run on; the count saturates.
            owner    = RD_LDR;
            beat_nxt = cnt_inc_sat(beat_cnt, BURST_MAX_C);
          end
        end else begin
          // Burst ended by the loader: this cycle falls back to default rules.
          owner     = cpu_rule_owner;
          wait_nxt  = cpu_rule_wait;
          state_nxt = ARB_CPU;
        end
      end
      default: begin
        state_nxt = ARB_CPU;
      end
    endcase
  end

  // Owner mux onto the memory port; with no owner the CPU address is presented.
  always_comb begin
    mux_addr  = bus.cpu_addr;
    mux_wdata = bus.cpu_wdata;
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    if (owner == RD_LDR) begin
      mux_addr  = bus.ldr_addr;
      mux_wdata = bus.ldr_wdata;
      mem_rd_c  = ~bus.ldr_we;
      mem_wr_c  = bus.ldr_we;
    end else if (owner == RD_CPU) begin
      mem_rd_c = cpu_is_rd;
      mem_wr_c = cpu_is_wr;
    end
    if (rst) begin
      mem_rd_c = 1'b0;
      mem_wr_c = 1'b0;
    end
  end

  // Tag each memory read with its owner so the return can be steered.
  always_comb begin
    rd_owner_nxt = mem_rd_c ? owner : RD_NONE;
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // Read-return owner register; reset drops any in-flight loader read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner <= RD_NONE;
    end else begin
      rd_owner <= rd_owner_nxt;
    end
  end

  // Sticky protocol error: CPU strobed read and write together.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bus.cpu_rd && bus.cpu_wr) begin
      err_q <= 1'b1;
    end
  end

  assign bus.mem_addr   = mux_addr;
  assign bus.mem_wdata  = mux_wdata;
  assign bus.mem_rd     = mem_rd_c;
  assign bus.mem_wr     = mem_wr_c;
  assign bus.ldr_gnt    = ~rst & (owner == RD_LDR);
  assign bus.cpu_stall  = ~rst & cpu_req & (owner != RD_CPU);
  assign bus.ldr_rvalid = (rd_owner == RD_LDR);
  assign bus.ldr_rdata  = bus.mem_rdata;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.err        = err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed arbitration scenarios plus randomised
// loader-only and CPU-only traffic against a small memory model. Loader read
// data is scoreboarded through exp_q.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW        = 5;
  localparam int DW        = 8;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_MAX = 8;
  localparam int DEPTH     = 1 << AW;

  logic       clk = 1'b0;
  logic       rst;
  arb_state_t dbg_state;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] exp_q  [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [DW-1:0] mem_init(input int i);
    return (i == 4) ? 8'h5A : 8'(i * 13 + 7);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_init(i);
    end else begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_gnt(input string tag, input logic gnt, input logic stall);
    check({tag, "_gnt"}, 32'(bus.ldr_gnt), 32'(gnt));
    check({tag, "_stall"}, 32'(bus.cpu_stall), 32'(stall));
  endtask

  // Scoreboard: every loader read return is matched against the queue.
  always @(negedge clk) begin
    if (bus.ldr_rvalid === 1'b1) begin
      if (exp_q.size() == 0) check("ldr_rvalid_unexpected", 32'(1), 32'(0));
      else check("ldr_rdata", 32'(bus.ldr_rdata), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_lock = 1'b0;
    bus.ldr_addr = '0; bus.ldr_wdata = '0;
  endtask

  task automatic ldr_drive(input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ldr_req = req; bus.ldr_we = we; bus.ldr_lock = lock;
    bus.ldr_addr = a; bus.ldr_wdata = d;
  endtask

  task automatic cpu_drive(input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          we;
    int            b;
    int            op;
    logic          cpu_pend;
    logic [DW-1:0] cpu_exp;

    for (int i = 0; i < DEPTH; i++) shadow[i] = mem_init(i);

    // Reset with both requesters active: nothing may reach the memory.
    idle_inputs();
    rst = 1'b1;
    cpu_drive(1'b1, 1'b0, 5'h02, 8'h00);
    ldr_drive(1'b1, 1'b0, 1'b0, 5'h09, 8'h00);
    for (int i = 0; i < 2; i++) begin
      settle();
      check("rst_mem_rd", 32'(bus.mem_rd), 32'(0));
      check("rst_mem_wr", 32'(bus.mem_wr), 32'(0));
      expect_gnt("rst", 1'b0, 1'b0);
      check("rst_err", 32'(bus.err), 32'(0));
      check("rst_rvalid", 32'(bus.ldr_rvalid), 32'(0));
      check("rst_state", 32'(dbg_state), 32'(ARB_CPU));
      next_cycle();
    end
    rst = 1'b0;
    settle();
    expect_gnt("post_rst", 1'b0, 1'b0);
    check("post_rst_mem_rd", 32'(bus.mem_rd), 32'(1));
    check("post_rst_addr", 32'(bus.mem_addr), 32'(5'h02));
    next_cycle();

    // Loader-only write: granted in the same cycle.
    idle_inputs();
    ldr_drive(1'b1, 1'b1, 1'b0, 5'h1A, 8'h3C);
    settle();
    check("cpu_rdata_after_rst", 32'(bus.cpu_rdata), 32'(shadow[2]));
    expect_gnt("ldr_wr", 1'b1, 1'b0);
    check("ldr_wr_mem_wr", 32'(bus.mem_wr), 32'(1));
    check("ldr_wr_mem_rd", 32'(bus.mem_rd), 32'(0));
    check("ldr_wr_addr", 32'(bus.mem_addr), 32'(5'h1A));
    check("ldr_wr_wdata", 32'(bus.mem_wdata), 32'(8'h3C));
    shadow[5'h1A] = 8'h3C;
    next_cycle();

    // Loader read: rvalid only in the following cycle.
    ldr_drive(1'b1, 1'b0, 1'b0, 5'h04, 8'h00);
    settle();
    expect_gnt("ldr_rd", 1'b1, 1'b0);
    check("ldr_rd_mem_rd", 32'(bus.mem_rd), 32'(1));
    check("ldr_rd_rvalid_n0", 32'(bus.ldr_rvalid), 32'(0));
    exp_q.push_back(shadow[5'h04]);
    next_cycle();
    idle_inputs();
    settle();
    check("ldr_rd_rvalid_n1", 32'(bus.ldr_rvalid), 32'(1));
    next_cycle();
    settle();
    check("ldr_rd_rvalid_n2", 32'(bus.ldr_rvalid), 32'(0));
    next_cycle();

    // Starvation: CPU wins MAX_WAIT cycles, then one forced loader grant.
    cpu_drive(1'b1, 1'b0, 5'h03, 8'h00);
    ldr_drive(1'b1, 1'b0, 1'b0, 5'h11, 8'h00);
    for (int c = 0; c < MAX_WAIT + 2; c++) begin
      settle();
      if (c < MAX_WAIT) begin
        expect_gnt("starve_cpu", 1'b0, 1'b0);
        check("starve_cpu_addr", 32'(bus.mem_addr), 32'(5'h03));
        if (c == 1) check("starve_cpu_rdata", 32'(bus.cpu_rdata), 32'(shadow[3]));
      end else if (c == MAX_WAIT) begin
        expect_gnt("starve_forced", 1'b1, 1'b1);
        check("starve_forced_addr", 32'(bus.mem_addr), 32'(5'h11));
        exp_q.push_back(shadow[5'h11]);
      end else begin
        expect_gnt("starve_after", 1'b0, 1'b0);
        check("starve_after_rvalid", 32'(bus.ldr_rvalid), 32'(1));
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Locked burst starting from a forced grant: BURST_MAX beats, then CPU.
    cpu_drive(1'b1, 1'b0, 5'h05, 8'h00);
    b = 0;
    for (int c = 0; c < MAX_WAIT + BURST_MAX + 2; c++) begin
      ldr_drive(1'b1, 1'b1, 1'b1, 5'(5'h10 + b), 8'($urandom_range(0, 255)));
      settle();
      if (c < MAX_WAIT) begin
        expect_gnt("burst_pre", 1'b0, 1'b0);
      end else if (c < MAX_WAIT + BURST_MAX) begin
        expect_gnt("burst_beat", 1'b1, 1'b1);
        check("burst_mem_wr", 32'(bus.mem_wr), 32'(1));
        check("burst_addr", 32'(bus.mem_addr), 32'(bus.ldr_addr));
        shadow[bus.ldr_addr] = bus.ldr_wdata;
        b++;
      end else if (c == MAX_WAIT + BURST_MAX) begin
        expect_gnt("burst_release", 1'b0, 1'b0);
        check("burst_release_addr", 32'(bus.mem_addr), 32'(5'h05));
      end else begin
        expect_gnt("burst_cpu_hold", 1'b0, 1'b0);
        check("burst_cpu_hold_state", 32'(dbg_state), 32'(ARB_CPU));
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Uncontended locked burst runs past BURST_MAX; a CPU request then ends it.
    for (int c = 0; c < BURST_MAX + 2; c++) begin
      ldr_drive(1'b1, 1'b1, 1'b1, 5'(5'h18 + c), 8'($urandom_range(0, 255)));
      settle();
      expect_gnt("sat_beat", 1'b1, 1'b0);
      shadow[bus.ldr_addr] = bus.ldr_wdata;
      next_cycle();
    end
    cpu_drive(1'b1, 1'b0, 5'h06, 8'h00);
    settle();
    expect_gnt("sat_release", 1'b0, 1'b0);
    check("sat_release_addr", 32'(bus.mem_addr), 32'(5'h06));
    check("sat_release_state", 32'(dbg_state), 32'(ARB_LDR));
    next_cycle();
    settle();
    expect_gnt("sat_cpu_next", 1'b0, 1'b0);
    check("sat_cpu_next_state", 32'(dbg_state), 32'(ARB_CPU));
    next_cycle();
    idle_inputs();
    next_cycle();

    // Lock dropped while the CPU asks: no loader beat, CPU owns.
    ldr_drive(1'b1, 1'b1, 1'b1, 5'h0C, 8'h99);
    settle();
    expect_gnt("lockdrop_first", 1'b1, 1'b0);
    shadow[5'h0C] = 8'h99;
    next_cycle();
    cpu_drive(1'b1, 1'b0, 5'h08, 8'h00);
    ldr_drive(1'b1, 1'b1, 1'b0, 5'h0D, 8'h11);
    settle();
    expect_gnt("lockdrop_cpu", 1'b0, 1'b0);
    check("lockdrop_addr", 32'(bus.mem_addr), 32'(5'h08));
    next_cycle();
    idle_inputs();
    next_cycle();

    // Simultaneous CPU read+write: treated as a write, err is sticky.
    cpu_drive(1'b1, 1'b1, 5'h07, 8'hA5);
    settle();
    check("err_mem_wr", 32'(bus.mem_wr), 32'(1));
    check("err_mem_rd", 32'(bus.mem_rd), 32'(0));
    check("err_wdata", 32'(bus.mem_wdata), 32'(8'hA5));
    shadow[5'h07] = 8'hA5;
    next_cycle();
    idle_inputs();
    settle();
    check("err_set", 32'(bus.err), 32'(1));
    next_cycle();
    settle();
    check("err_sticky", 32'(bus.err), 32'(1));
    next_cycle();

    // Reset arriving on a loader read beat inside a locked burst.
    ldr_drive(1'b1, 1'b1, 1'b1, 5'h0E, 8'h77);
    settle();
    expect_gnt("rstburst_first", 1'b1, 1'b0);
    shadow[5'h0E] = 8'h77;
    next_cycle();
    ldr_drive(1'b1, 1'b0, 1'b1, 5'h04, 8'h00);
    rst = 1'b1;
    settle();
    check("rstburst_gnt", 32'(bus.ldr_gnt), 32'(0));
    check("rstburst_mem_rd", 32'(bus.mem_rd), 32'(0));
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    settle();
    check("rstburst_rvalid", 32'(bus.ldr_rvalid), 32'(0));
    check("rstburst_err", 32'(bus.err), 32'(0));
    check("rstburst_state", 32'(dbg_state), 32'(ARB_CPU));
    next_cycle();
    // Reset reloads the memory model with its initial image.
    for (int i = 0; i < DEPTH; i++) shadow[i] = mem_init(i);

    // Random loader-only traffic: always granted, reads scoreboarded.
    for (int i = 0; i < 24; i++) begin
      a  = 5'($urandom_range(0, DEPTH - 1));
      d  = 8'($urandom_range(0, 255));
      we = 1'($urandom_range(0, 1));
      ldr_drive(1'b1, we, 1'b0, a, d);
      settle();
      expect_gnt("rnd_ldr", 1'b1, 1'b0);
      if (we) shadow[a] = d;
      else exp_q.push_back(shadow[a]);
      next_cycle();
    end
    idle_inputs();

    // Random CPU-only traffic: never stalled, read data checked next cycle.
    cpu_pend = 1'b0;
    cpu_exp  = '0;
    for (int i = 0; i < 24; i++) begin
      a  = 5'($urandom_range(0, DEPTH - 1));
      d  = 8'($urandom_range(0, 255));
      op = int'($urandom_range(0, 2));
      cpu_drive(op == 0, op == 1, a, d);
      settle();
      if (cpu_pend) check("rnd_cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_exp));
      expect_gnt("rnd_cpu", 1'b0, 1'b0);
      check("rnd_cpu_mem_rd", 32'(bus.mem_rd), 32'(op == 0));
      check("rnd_cpu_mem_wr", 32'(bus.mem_wr), 32'(op == 1));
      if (op == 1) shadow[a] = d;
      cpu_pend = (op == 0);
      cpu_exp  = shadow[a];
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    next_cycle();
    settle();
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
